// File: rtl/window_shifter_pkg.sv
// rtl/window_shifter_pkg.sv - shared widths and FSM states for the 3x3 window front end
package window_shifter_pkg;

  localparam int PIX_W       = 8;
  localparam int FILTER_SIZE = 3;
  localparam int WIN_W       = PIX_W * FILTER_SIZE * FILTER_SIZE;

  // FILL: taking pixels; WAIT: window presented to engine; FDONE: end-of-frame pulse
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    FDONE = 2'd2
  } state_t;

endpackage

// File: rtl/window_shifter_line_buffer.sv
// rtl/window_shifter_line_buffer.sv - one image row of pixel storage, async read, sync write
import window_shifter_pkg::*;

module line_buffer #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Read returns the pre-write contents so the caller sees last row's pixel at this column
  assign rdata = mem[addr];

  // Contents are deliberately not reset; stale rows are masked by the window-valid rule
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_shifter.sv
// rtl/window_shifter.sv - raster pixel stream to 3x3 window with engine handshake
import window_shifter_pkg::*;

module window_shifter #(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int FILTER_SIZE  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  input  logic              shift_buffer,
  output logic [WIN_W-1:0]  window_out,
  output logic              window_valid,
  output logic [15:0]       win_idx,
  output logic              frame_done
);

  localparam int FS = FILTER_SIZE;
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(FS - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(FS - 1);

  state_t           state, state_next;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             last_q;
  logic             accept;
  logic             win_pos;
  logic             is_last;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] win [FS][FS];

  assign accept  = pix_valid && (state == FILL);
  assign win_pos = (row >= ROW_MIN) && (col >= COL_MIN);
  assign is_last = (row == ROW_LAST) && (col == COL_LAST);

  // lb1 holds the row two above the incoming pixel, lb0 the row directly above
  line_buffer #(.DEPTH(IMAGE_WIDTH), .ADDR_W(CW)) lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (pix_data),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMAGE_WIDTH), .ADDR_W(CW)) lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; shift_buffer only matters while the window is presented
  always_comb begin
    state_next   = state;
    pix_ready    = 1'b0;
    window_valid = 1'b0;
    frame_done   = 1'b0;
    case (state)
      FILL: begin
        pix_ready = 1'b1;
        if (pix_valid && win_pos) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        window_valid = 1'b1;
        if (shift_buffer) begin
          state_next = last_q ? FDONE : FILL;
        end
      end
      FDONE: begin
        frame_done = 1'b1;
        state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Raster position, end-of-frame flag and window index
  always_ff @(posedge clk) begin
    if (!rst) begin
      col     <= '0;
      row     <= '0;
      last_q  <= 1'b0;
      win_idx <= '0;
    end else begin
      if (accept) begin
        last_q <= is_last;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if ((state == WAIT) && shift_buffer) begin
        win_idx <= win_idx + 16'd1;
      end
      if (state == FDONE) begin
        col     <= '0;
        row     <= '0;
        win_idx <= '0;
      end
    end
  end

  // Window shifts left on every accept; new right column comes from both buffers and the input
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < FS; r++) begin
        for (int c = 0; c < FS; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < FS; r++) begin
        for (int c = 0; c < FS - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
      end
      win[0][FS-1]    <= lb1_rd;
      win[1][FS-1]    <= lb0_rd;
      win[FS-1][FS-1] <= pix_data;
    end
  end

  // Flatten: row-major, oldest row and oldest column in the low bytes
  always_comb begin
    window_out = '0;
    for (int r = 0; r < FS; r++) begin
      for (int c = 0; c < FS; c++) begin
        window_out[(r*FS+c)*PIX_W +: PIX_W] = win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_window_shifter.sv
// tb/tb_window_shifter.sv - self-checking bench for window_shifter at 4x4
module tb_window_shifter;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'd0;
  logic        pix_ready;
  logic        shift_buffer = 1'b0;
  logic [71:0] window_out;
  logic        window_valid;
  logic [15:0] win_idx;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  window_shifter #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_SIZE(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .shift_buffer (shift_buffer),
    .window_out   (window_out),
    .window_valid (window_valid),
    .win_idx      (win_idx),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t: timed out waiting on the DUT", name, $time);
  endtask

  // Model: image memory per frame, window derived directly from the raster position rules
  logic [7:0]  img [H][W];
  int          m_row = 0, m_col = 0, exp_idx = 0;
  logic        m_init = 1'b0, exp_valid = 1'b0, exp_fd = 1'b0, m_last = 1'b0;
  logic [71:0] exp_win = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_init = 1'b1; m_row = 0; m_col = 0;
      exp_valid = 1'b0; exp_fd = 1'b0; m_last = 1'b0;
    end else if (m_init) begin
      if (exp_fd) begin
        exp_fd = 1'b0;
      end else if (exp_valid) begin
        if (shift_buffer) begin
          exp_valid = 1'b0;
          exp_fd = m_last;
        end
      end else if (pix_valid) begin
        img[m_row][m_col] = pix_data;
        if (m_row >= 2 && m_col >= 2) begin
          exp_valid = 1'b1;
          m_last  = (m_row == H - 1) && (m_col == W - 1);
          exp_idx = (m_row - 2) * (W - 2) + (m_col - 2);
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              exp_win[(r*3+c)*8 +: 8] = img[m_row-2+r][m_col-2+c];
        end
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row = (m_row + 1) % H;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus event counters
  logic prev_wv = 1'b0;
  int   win_rises = 0, fd_pulses = 0;

  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_pix_ready", 72'(pix_ready), 72'(!(exp_valid || exp_fd)));
      chk("cyc_window_valid", 72'(window_valid), 72'(exp_valid));
      chk("cyc_frame_done", 72'(frame_done), 72'(exp_fd));
      if (exp_valid) begin
        chk("cyc_window_out", window_out, exp_win);
        chk("cyc_win_idx", 72'(win_idx), 72'(exp_idx));
      end
      if (window_valid && !prev_wv) win_rises++;
      if (frame_done) fd_pulses++;
      prev_wv = window_valid;
    end
  end

  // Present one pixel and return in the cycle after it is accepted
  task automatic send(input logic [7:0] v);
    int t;
    pix_valid = 1'b1;
    pix_data  = v;
    t = 0;
    while (!pix_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail("send");
    @(negedge clk);
  endtask

  // Act as the engine: hold the window d cycles, then pulse shift_buffer
  task automatic consume(input int d);
    int t;
    t = 0;
    while (!window_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail("consume");
    repeat (d) @(negedge clk);
    shift_buffer = 1'b1;
    @(negedge clk);
    shift_buffer = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < W * H; k++) begin
      send(8'(base + k));
      pix_valid = 1'b0;
      if (base == 100 && k == 10) begin
        chk("frame2_first_window", window_out,
            {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100});
        chk("frame2_first_idx", 72'(win_idx), 72'd0);
      end
      if ((k / W) >= 2 && (k % W) >= 2) consume(k % 3);
    end
  endtask

  int wr0, fd0;

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_pix_ready", 72'(pix_ready), 72'd1);
    chk("reset_window_valid", 72'(window_valid), 72'd0);
    chk("reset_frame_done", 72'(frame_done), 72'd0);
    chk("reset_win_idx", 72'(win_idx), 72'd0);
    chk("reset_window_out", window_out, 72'd0);

    for (int k = 0; k <= 10; k++) send(8'(k));
    chk("first_window_valid", 72'(window_valid), 72'd1);
    chk("first_window", window_out, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
    chk("first_idx", 72'(win_idx), 72'd0);

    pix_data = 8'd11;
    for (int i = 0; i < 5; i++) begin
      chk("hold_pix_ready", 72'(pix_ready), 72'd0);
      chk("hold_window", window_out, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
      @(negedge clk);
    end
    shift_buffer = 1'b1;
    @(negedge clk);
    shift_buffer = 1'b0;
    chk("after_shift_ready", 72'(pix_ready), 72'd1);
    chk("after_shift_valid", 72'(window_valid), 72'd0);
    send(8'd11);
    pix_valid = 1'b0;
    chk("win1_idx", 72'(win_idx), 72'd1);
    consume(2);

    send(8'd12);
    send(8'd13);
    pix_valid = 1'b0;
    chk("row_wrap_no_window", 72'(window_valid), 72'd0);
    send(8'd14);
    pix_valid = 1'b0;
    chk("win2", window_out, {8'd14, 8'd13, 8'd12, 8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4});
    chk("win2_idx", 72'(win_idx), 72'd2);
    consume(1);
    send(8'd15);
    pix_valid = 1'b0;
    chk("win3_idx", 72'(win_idx), 72'd3);
    consume(0);
    chk("frame_done_high", 72'(frame_done), 72'd1);
    chk("frame_done_not_ready", 72'(pix_ready), 72'd0);
    @(negedge clk);
    chk("frame_done_low", 72'(frame_done), 72'd0);
    chk("frame_done_then_ready", 72'(pix_ready), 72'd1);

    wr0 = win_rises;
    fd0 = fd_pulses;
    send_frame(100);
    repeat (2) @(negedge clk);
    chk("frame2_windows", 72'(win_rises - wr0), 72'd4);
    chk("frame2_done_pulses", 72'(fd_pulses - fd0), 72'd1);

    for (int k = 0; k <= 10; k++) send(8'(50 + k));
    pix_valid = 1'b0;
    chk("pre_reset_wait", 72'(window_valid), 72'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_valid", 72'(window_valid), 72'd0);
    chk("mid_reset_idx", 72'(win_idx), 72'd0);
    chk("mid_reset_window", window_out, 72'd0);
    chk("mid_reset_ready", 72'(pix_ready), 72'd1);
    rst = 1'b1;
    @(negedge clk);

    wr0 = win_rises;
    fd0 = fd_pulses;
    send_frame(200);
    repeat (2) @(negedge clk);
    chk("post_reset_windows", 72'(win_rises - wr0), 72'd4);
    chk("post_reset_done_pulses", 72'(fd_pulses - fd0), 72'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
